// File: rtl/ram_arb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Package     : ram_arb_pkg                                                  |
// | Description : State, grant and byte-lane encodings for ram_arbiter.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2,
    GNT_DMA  = 2'd3
  } gnt_t;

  localparam logic [1:0] BSEL_OFF  = 2'b00;
  localparam logic [1:0] BSEL_BOTH = 2'b11;
  localparam logic [1:0] BSEL_HI   = 2'b10;
  localparam logic [1:0] BSEL_LO   = 2'b01;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arb_sel.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : ram_arb_sel                                                  |
// | Description : Combinational winner selection (video > CPU > DMA, with CPU  |
// |               starvation override). DMA input present with RAM_ARB_DMA_EN. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ram_arb_sel
  import ram_arb_pkg::*;
#(
  parameter  int STARVE_MAX = 4,
  localparam int SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          vid_req_i,
  input  logic          cpu_req_i,
`ifdef RAM_ARB_DMA_EN
  input  logic          dma_req_i,
`endif
  input  logic [SW-1:0] starve_cnt_i,
  output gnt_t          gnt_o
);

  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);

  always_comb begin
    gnt_o = GNT_NONE;
    if (cpu_req_i && (starve_cnt_i == C_STARVE_MAX)) begin
      gnt_o = GNT_CPU;
    end else if (vid_req_i) begin
      gnt_o = GNT_VID;
    end else if (cpu_req_i) begin
      gnt_o = GNT_CPU;
    end
`ifdef RAM_ARB_DMA_EN
    else if (dma_req_i) begin
      gnt_o = GNT_DMA;
    end
`endif
  end

endmodule : ram_arb_sel
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : ram_arbiter                                                  |
// | Description : Shares one 16-bit SRAM between video fetch and CPU; fixed    |
// |               length CE/OE/WE sequencing. RAM_ARB_DMA_EN adds a DMA port.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int ACC_CYC    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_ack_o,
  output logic              vid_valid_o,
  output logic [15:0]       vid_data_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic              cpu_hi_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [7:0]        cpu_data_i,
  output logic              cpu_ack_o,
  output logic              cpu_valid_o,
  output logic [15:0]       cpu_data_o,
`ifdef RAM_ARB_DMA_EN
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic              dma_hi_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [7:0]        dma_data_i,
  output logic              dma_ack_o,
  output logic              dma_valid_o,
  output logic [15:0]       dma_data_o,
`endif
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_data_o,
  input  logic [15:0]       ram_data_i,
  output logic              ram_ce_o,
  output logic              ram_oe_o,
  output logic              ram_we_o,
  output logic [1:0]        ram_bsel_o
);

  localparam int CNT_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(ACC_CYC - 1);
  localparam logic [SW-1:0]    C_STARVE_MAX = SW'(STARVE_MAX);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  gnt_t              r_gnt, w_gnt_sel;
  logic [SW-1:0]     r_starve;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_we;
  logic              r_hi;
  logic [15:0]       r_vid_data;
  logic [15:0]       r_cpu_data;
  logic              w_load;
  logic              w_capture;
  logic              w_first;
  logic              w_done_rd;

  ram_arb_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .vid_req_i    (vid_req_i),
    .cpu_req_i    (cpu_req_i),
`ifdef RAM_ARB_DMA_EN
    .dma_req_i    (dma_req_i),
`endif
    .starve_cnt_i (r_starve),
    .gnt_o        (w_gnt_sel)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_first     = 1'b0;
    w_done_rd   = 1'b0;
    ram_ce_o    = 1'b0;
    ram_oe_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_bsel_o  = BSEL_OFF;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_sel != GNT_NONE) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ram_ce_o = 1'b1;
        w_first  = (r_cnt == '0);
        if (r_we) begin
          ram_we_o   = 1'b1;
          ram_bsel_o = r_hi ? BSEL_HI : BSEL_LO;
        end else begin
          ram_oe_o   = 1'b1;
          ram_bsel_o = BSEL_BOTH;
        end
        if (r_cnt == C_CNT_LAST) begin
          w_capture   = ~r_we;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_done_rd   = ~r_we;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign vid_ack_o   = w_first   && (r_gnt == GNT_VID);
  assign cpu_ack_o   = w_first   && (r_gnt == GNT_CPU);
  assign vid_valid_o = w_done_rd && (r_gnt == GNT_VID);
  assign cpu_valid_o = w_done_rd && (r_gnt == GNT_CPU);
  assign vid_data_o  = r_vid_data;
  assign cpu_data_o  = r_cpu_data;
  assign ram_addr_o  = r_addr;
  assign ram_data_o  = r_wdata;

`ifdef RAM_ARB_DMA_EN
  logic [15:0] r_dma_data;

  assign dma_ack_o   = w_first   && (r_gnt == GNT_DMA);
  assign dma_valid_o = w_done_rd && (r_gnt == GNT_DMA);
  assign dma_data_o  = r_dma_data;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dma_data <= '0;
    end else if (w_capture && (r_gnt == GNT_DMA)) begin
      r_dma_data <= ram_data_i;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_gnt      <= GNT_NONE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_hi       <= 1'b0;
      r_vid_data <= '0;
      r_cpu_data <= '0;
    end else begin
      if (w_load) begin
        r_gnt <= w_gnt_sel;
        case (w_gnt_sel)
          GNT_VID: begin
            r_addr  <= vid_addr_i;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_hi    <= 1'b0;
          end
          GNT_CPU: begin
            r_addr  <= cpu_addr_i;
            r_wdata <= cpu_data_i;
            r_we    <= cpu_we_i;
            r_hi    <= cpu_hi_i;
          end
`ifdef RAM_ARB_DMA_EN
          GNT_DMA: begin
            r_addr  <= dma_addr_i;
            r_wdata <= dma_data_i;
            r_we    <= dma_we_i;
            r_hi    <= dma_hi_i;
          end
`endif
          default: begin
            r_addr <= r_addr;
          end
        endcase
      end
      if (w_capture && (r_gnt == GNT_VID)) begin
        r_vid_data <= ram_data_i;
      end
      if (w_capture && (r_gnt == GNT_CPU)) begin
        r_cpu_data <= ram_data_i;
      end
    end
  end

  // Starvation counter only moves on IDLE-cycle decisions; DMA grants leave it alone.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_starve <= '0;
    end else if (r_state == ST_IDLE) begin
      if (!cpu_req_i || (w_gnt_sel == GNT_CPU)) begin
        r_starve <= '0;
      end else if ((w_gnt_sel == GNT_VID) && (r_starve != C_STARVE_MAX)) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_ram_arbiter                                               |
// | Description : Directed self-checking bench for ram_arbiter (ACC_CYC=2,     |
// |               STARVE_MAX=4); DMA cases run when RAM_ARB_DMA_EN is defined. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ram_arbiter;

  localparam int ADDR_W = 18;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              vid_req_i = 1'b0;
  logic [ADDR_W-1:0] vid_addr_i = '0;
  logic              vid_ack_o, vid_valid_o;
  logic [15:0]       vid_data_o;
  logic              cpu_req_i = 1'b0, cpu_we_i = 1'b0, cpu_hi_i = 1'b0;
  logic [ADDR_W-1:0] cpu_addr_i = '0;
  logic [7:0]        cpu_data_i = '0;
  logic              cpu_ack_o, cpu_valid_o;
  logic [15:0]       cpu_data_o;
`ifdef RAM_ARB_DMA_EN
  logic              dma_req_i = 1'b0, dma_we_i = 1'b0, dma_hi_i = 1'b0;
  logic [ADDR_W-1:0] dma_addr_i = '0;
  logic [7:0]        dma_data_i = '0;
  logic              dma_ack_o, dma_valid_o;
  logic [15:0]       dma_data_o;
`endif
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_data_o;
  logic [15:0]       ram_data_i = '0;
  logic              ram_ce_o, ram_oe_o, ram_we_o;
  logic [1:0]        ram_bsel_o;

  int err_cnt = 0;
  int chk_cnt = 0;

  ram_arbiter #(.ADDR_W(ADDR_W), .ACC_CYC(2), .STARVE_MAX(4)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .vid_req_i   (vid_req_i),
    .vid_addr_i  (vid_addr_i),
    .vid_ack_o   (vid_ack_o),
    .vid_valid_o (vid_valid_o),
    .vid_data_o  (vid_data_o),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_hi_i    (cpu_hi_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_ack_o   (cpu_ack_o),
    .cpu_valid_o (cpu_valid_o),
    .cpu_data_o  (cpu_data_o),
`ifdef RAM_ARB_DMA_EN
    .dma_req_i   (dma_req_i),
    .dma_we_i    (dma_we_i),
    .dma_hi_i    (dma_hi_i),
    .dma_addr_i  (dma_addr_i),
    .dma_data_i  (dma_data_i),
    .dma_ack_o   (dma_ack_o),
    .dma_valid_o (dma_valid_o),
    .dma_data_o  (dma_data_o),
`endif
    .ram_addr_o  (ram_addr_o),
    .ram_data_o  (ram_data_o),
    .ram_data_i  (ram_data_i),
    .ram_ce_o    (ram_ce_o),
    .ram_oe_o    (ram_oe_o),
    .ram_we_o    (ram_we_o),
    .ram_bsel_o  (ram_bsel_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [4:0] strobes();
    return {ram_ce_o, ram_oe_o, ram_we_o, ram_bsel_o};
  endfunction

  // Waits for the next vid/cpu ack and returns {vid_ack, cpu_ack}.
  task automatic wait_grant(output logic [1:0] who);
    who = 2'b00;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (vid_ack_o || cpu_ack_o) begin
        who = {vid_ack_o, cpu_ack_o};
        break;
      end
    end
    if (who == 2'b00) check("grant_timeout", 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [1:0] who;
    logic [9:0] seq_v;
    logic       any_evt;
    seq_v = 10'b1111011110; // 1 = video grant, MSB first: V,V,V,V,C,V,V,V,V,C

    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_n_i = 1'b1;
    tick();
    check("rst_strobes", 32'(strobes()), 32'h00);
    check("rst_flags", {28'd0, vid_ack_o, vid_valid_o, cpu_ack_o, cpu_valid_o}, 32'h0);
    check("rst_data", {vid_data_o, cpu_data_o}, 32'h0);
    check("rst_addr", 32'(ram_addr_o), 32'h0);
    tick(); tick();
    check("idle_strobes", 32'(strobes()), 32'h00);

    // video read
    vid_req_i = 1'b1; vid_addr_i = 18'h01234;
    tick();
    check("vid_ack", 32'(vid_ack_o), 32'd1);
    check("vid_strobe_c1", 32'(strobes()), 32'h1B);
    check("vid_addr", 32'(ram_addr_o), 32'h01234);
    vid_req_i = 1'b0; vid_addr_i = 18'h3FFFF; ram_data_i = 16'hBEEF;
    tick();
    check("vid_ack_c2", 32'(vid_ack_o), 32'd0);
    check("vid_strobe_c2", 32'(strobes()), 32'h1B);
    check("vid_addr_held", 32'(ram_addr_o), 32'h01234);
    tick();
    check("vid_done_strobe", 32'(strobes()), 32'h00);
    check("vid_valid", 32'(vid_valid_o), 32'd1);
    check("vid_data", 32'(vid_data_o), 32'hBEEF);
    ram_data_i = 16'h0000;
    tick();
    check("vid_valid_once", 32'(vid_valid_o), 32'd0);
    check("vid_data_hold", 32'(vid_data_o), 32'hBEEF);

    // CPU write, upper lane
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_hi_i = 1'b1; cpu_addr_i = 18'h00F00; cpu_data_i = 8'h5A;
    tick();
    check("cpuw_ack", 32'(cpu_ack_o), 32'd1);
    check("cpuw_strobe_c1", 32'(strobes()), 32'h16);
    check("cpuw_addr", 32'(ram_addr_o), 32'h00F00);
    check("cpuw_data", 32'(ram_data_o), 32'h5A);
    cpu_req_i = 1'b0; cpu_data_i = 8'hFF; cpu_addr_i = '0; cpu_hi_i = 1'b0;
    tick();
    check("cpuw_strobe_c2", 32'(strobes()), 32'h16);
    check("cpuw_data_held", 32'(ram_data_o), 32'h5A);
    tick();
    check("cpuw_done", {27'd0, strobes()}, 32'h00);
    check("cpuw_no_valid", 32'(cpu_valid_o), 32'd0);
    tick();
    cpu_we_i = 1'b0;

    // simultaneous video + CPU read
    vid_req_i = 1'b1; vid_addr_i = 18'h00010; cpu_req_i = 1'b1; cpu_addr_i = 18'h00020;
    ram_data_i = 16'h1234;
    tick();
    check("both_first", {30'd0, vid_ack_o, cpu_ack_o}, 32'h2);
    vid_req_i = 1'b0;
    tick(); tick();
    check("both_vid_data", 32'(vid_data_o), 32'h1234);
    tick();
    check("both_idle_gap", 32'(strobes()), 32'h00);
    tick();
    check("both_second", {30'd0, vid_ack_o, cpu_ack_o}, 32'h1);
    check("both_cpu_addr", 32'(ram_addr_o), 32'h00020);
    cpu_req_i = 1'b0; ram_data_i = 16'hA55A;
    tick(); tick();
    check("cpur_valid", 32'(cpu_valid_o), 32'd1);
    check("cpur_data", 32'(cpu_data_o), 32'hA55A);
    check("vid_data_kept", 32'(vid_data_o), 32'h1234);
    tick();

    // starvation: both requesters held high
    vid_req_i = 1'b1; cpu_req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_grant(who);
      check($sformatf("starve_seq_%0d", i), 32'(who), seq_v[9-i] ? 32'h2 : 32'h1);
    end
    vid_req_i = 1'b0; cpu_req_i = 1'b0;
    tick(); tick(); tick(); tick();
    check("starve_idle", 32'(strobes()), 32'h00);

`ifdef RAM_ARB_DMA_EN
    dma_req_i = 1'b1; dma_addr_i = 18'h00777; ram_data_i = 16'hD00D;
    tick();
    check("dma_ack", 32'(dma_ack_o), 32'd1);
    dma_req_i = 1'b0;
    tick(); tick();
    check("dma_valid", 32'(dma_valid_o), 32'd1);
    check("dma_data", 32'(dma_data_o), 32'hD00D);
    tick();
    dma_req_i = 1'b1; cpu_req_i = 1'b1;
    tick();
    check("dma_cpu_first", {30'd0, cpu_ack_o, dma_ack_o}, 32'h2);
    cpu_req_i = 1'b0;
    tick(); tick(); tick(); tick();
    check("dma_second", {30'd0, cpu_ack_o, dma_ack_o}, 32'h1);
    dma_req_i = 1'b0;
    tick(); tick(); tick();
`endif

    // reset mid-access
    cpu_req_i = 1'b1; cpu_addr_i = 18'h00040;
    tick();
    check("mid_ack", 32'(cpu_ack_o), 32'd1);
    check("mid_strobe", 32'(strobes()), 32'h1B);
    cpu_req_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_async_strobe", 32'(strobes()), 32'h00);
    check("rst_async_data", {vid_data_o, cpu_data_o}, 32'h0);
    tick();
    @(negedge clk_i) rst_n_i = 1'b1;
    any_evt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      any_evt |= vid_ack_o | cpu_ack_o | vid_valid_o | cpu_valid_o | ram_ce_o;
    end
    check("post_rst_quiet", 32'(any_evt), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_ram_arbiter
`default_nettype wire
